// File: rtl/ahb_ram_slave.sv
// AHB-Lite data RAM responder. It registers the address phase, inserts WAIT_STATES wait
// cycles, merges byte/half/word writes and returns right-justified, extended read data.
module ahb_ram_slave #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        HSEL2,
  input  logic [31:0] Haddr,
  input  logic [1:0]  Htrans,
  input  logic        Hwrite,
  input  logic [2:0]  Hsize,
  input  logic [3:0]  Hprot,
  input  logic [31:0] Hwdata,
  input  logic        Is_signed,
  input  logic        hready,
  output logic [31:0] hrdata_data,
  output logic        hready_data,
  output logic        hresp_data
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

  typedef enum logic [2:0] {
    StIdle,
    StWait,
    StData,
    StErr1,
    StErr2
  } state_e;

  state_e          state_q;
  logic [IdxW+1:0] addr_q;
  logic [1:0]      size_q;
  logic            write_q;
  logic            signed_q;
  logic [3:0]      cnt_q;
  logic            hready_q;
  logic            hresp_q;

  logic [31:0]     mem [DEPTH_WORDS];

  logic            can_accept;
  logic            accept;
  logic            acc_err;
  logic [IdxW-1:0] idx;
  logic [31:0]     rword;
  logic [7:0]      rbyte;
  logic [15:0]     rhalf;
  logic [3:0]      wstrb;

  // Hprot and the BUSY/SEQ distinction carry no meaning for a RAM.
  logic            unused_inputs;
  assign unused_inputs = ^{Hprot, Htrans[0]};

  // Address-phase decode: only states whose data phase is ending (or idle) may accept.
  always_comb begin
    can_accept = (state_q == StIdle) || (state_q == StData) || (state_q == StErr2);
    accept     = can_accept & HSEL2 & Htrans[1] & hready;
    acc_err    = Hsize[2] | (&Hsize[1:0])
               | ((Hsize == 3'b001) & Haddr[0])
               | ((Hsize == 3'b010) & (|Haddr[1:0]))
               | ({2'b00, Haddr[31:2]} >= DEPTH_WORDS);
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      size_q   <= '0;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      cnt_q    <= '0;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StWait: begin
          cnt_q   <= cnt_q - 4'd1;
          hresp_q <= 1'b0;
          if (cnt_q == 4'd1) begin
            state_q  <= StData;
            hready_q <= 1'b1;
          end
        end
        StErr1: begin
          state_q  <= StErr2;
          hready_q <= 1'b1;
          hresp_q  <= 1'b1;
        end
        default: begin
          if (accept) begin
            addr_q   <= Haddr[IdxW+1:0];
            size_q   <= Hsize[1:0];
            write_q  <= Hwrite;
            signed_q <= Is_signed;
            if (acc_err) begin
              state_q  <= StErr1;
              hready_q <= 1'b0;
              hresp_q  <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              state_q  <= StWait;
              cnt_q    <= 4'(WAIT_STATES);
              hready_q <= 1'b0;
              hresp_q  <= 1'b0;
            end else begin
              state_q  <= StData;
              hready_q <= 1'b1;
              hresp_q  <= 1'b0;
            end
          end else begin
            state_q  <= StIdle;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign idx = addr_q[IdxW+1:2];

  always_comb begin
    wstrb = 4'b1111;
    unique case (size_q)
      2'b00:   wstrb = 4'b0001 << addr_q[1:0];
      2'b01:   wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
      default: wstrb = 4'b1111;
    endcase
  end

  // Read path is combinational from the array so a write committed on the previous edge
  // is visible to a back-to-back read without forwarding.
  always_comb begin
    rword       = mem[idx];
    rbyte       = rword[{addr_q[1:0], 3'b000} +: 8];
    rhalf       = addr_q[1] ? rword[31:16] : rword[15:0];
    hrdata_data = '0;
    if ((state_q == StData) && !write_q) begin
      unique case (size_q)
        2'b00:   hrdata_data = {{24{signed_q & rbyte[7]}}, rbyte};
        2'b01:   hrdata_data = {{16{signed_q & rhalf[15]}}, rhalf};
        default: hrdata_data = rword;
      endcase
    end
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge hclk) begin
    if ((state_q == StData) && write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) begin
          mem[idx][8*i +: 8] <= Hwdata[8*i +: 8];
        end
      end
    end
  end

  assign hready_data = hready_q;
  assign hresp_data  = hresp_q;

endmodule

// File: tb/tb_ahb_ram_slave.sv
// Directed bench for ahb_ram_slave: one instance with zero wait states, one with two,
// sharing a bus driver; expected responses queue at address phase and pop at completion.
module tb_ahb_ram_slave;

  logic        hclk = 1'b0;
  always #5 hclk = ~hclk;

  logic        hresetn;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        is_signed;
  logic        use2;

  logic        hready;
  logic        hresp;
  logic [31:0] rdata;
  logic        hrdy0, hrdy2, hresp0, hresp2;
  logic [31:0] rd0, rd2;

  int checks = 0;
  int errors = 0;

  ahb_ram_slave #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .HSEL2       (hsel & ~use2),
    .Haddr       (haddr),
    .Htrans      (htrans),
    .Hwrite      (hwrite),
    .Hsize       (hsize),
    .Hprot       (4'b0011),
    .Hwdata      (hwdata),
    .Is_signed   (is_signed),
    .hready      (hready),
    .hrdata_data (rd0),
    .hready_data (hrdy0),
    .hresp_data  (hresp0)
  );

  ahb_ram_slave #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) dut2 (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .HSEL2       (hsel & use2),
    .Haddr       (haddr),
    .Htrans      (htrans),
    .Hwrite      (hwrite),
    .Hsize       (hsize),
    .Hprot       (4'b0011),
    .Hwdata      (hwdata),
    .Is_signed   (is_signed),
    .hready      (hready),
    .hrdata_data (rd2),
    .hready_data (hrdy2),
    .hresp_data  (hresp2)
  );

  assign hready = use2 ? hrdy2 : hrdy0;
  assign hresp  = use2 ? hresp2 : hresp0;
  assign rdata  = use2 ? rd2 : rd0;

  typedef struct {
    bit          rd;
    bit          err;
    logic [31:0] data;
    int          waits;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [int];

  bit          tr_write  [16];
  logic [31:0] tr_addr   [16];
  logic [2:0]  tr_size   [16];
  bit          tr_signed [16];
  logic [31:0] tr_wdata  [16];
  int          ntr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic add(input bit w, input logic [31:0] a, input logic [2:0] s, input bit sg,
                     input logic [31:0] wd);
    tr_write[ntr]  = w;
    tr_addr[ntr]   = a;
    tr_size[ntr]   = s;
    tr_signed[ntr] = sg;
    tr_wdata[ntr]  = wd;
    ntr++;
  endtask

  function automatic bit bad(input logic [31:0] a, input logic [2:0] s);
    return (s >= 3'd3) || (s == 3'd1 && a[0]) || (s == 3'd2 && a[1:0] != 2'b00) ||
           (a[31:2] >= 30'd1024);
  endfunction

  function automatic int key(input logic [31:0] a);
    return (use2 ? 4096 : 0) + int'(a[31:2]);
  endfunction

  // Builds the expected response for transfer k and applies writes to the model.
  task automatic push(input int k);
    exp_t        e;
    logic [31:0] w;
    logic [31:0] sh;
    logic [31:0] a;
    bit          sel;
    a       = tr_addr[k];
    e.rd    = !tr_write[k];
    e.err   = bad(a, tr_size[k]);
    e.waits = e.err ? 1 : (use2 ? 2 : 0);
    e.data  = 32'h0;
    if (!e.err) begin
      w = model.exists(key(a)) ? model[key(a)] : 32'h0;
      if (tr_write[k]) begin
        for (int b = 0; b < 4; b++) begin
          sel = (tr_size[k] == 3'd2) || (tr_size[k] == 3'd1 && (b / 2) == int'(a[1])) ||
                (tr_size[k] == 3'd0 && b == int'(a[1:0]));
          if (sel) w[8*b +: 8] = tr_wdata[k][8*b +: 8];
        end
        model[key(a)] = w;
      end else if (tr_size[k] == 3'd0) begin
        sh     = w >> (8 * a[1:0]);
        e.data = sh & 32'hFF;
        if (tr_signed[k] && e.data[7]) e.data = e.data | 32'hFFFF_FF00;
      end else if (tr_size[k] == 3'd1) begin
        sh     = w >> (16 * a[1]);
        e.data = sh & 32'hFFFF;
        if (tr_signed[k] && e.data[15]) e.data = e.data | 32'hFFFF_0000;
      end else begin
        e.data = w;
      end
    end
    sb.push_back(e);
  endtask

  // Issues the queued transfers back to back and checks every data-phase cycle.
  task automatic run_burst();
    int   cyc;
    int   exp_cyc;
    int   waits;
    bit   done;
    exp_t e;
    cyc     = 0;
    exp_cyc = 1;
    for (int k = 0; k <= ntr; k++) begin
      if (k < ntr) begin
        hsel      = 1'b1;
        htrans    = (k == 0) ? 2'b10 : 2'b11;
        haddr     = tr_addr[k];
        hwrite    = tr_write[k];
        hsize     = tr_size[k];
        is_signed = tr_signed[k];
        push(k);
        exp_cyc += sb[$].waits + 1;
      end else begin
        hsel   = 1'b0;
        htrans = 2'b00;
        haddr  = 32'h0;
        hwrite = 1'b0;
      end
      hwdata = (k > 0 && tr_write[k-1]) ? tr_wdata[k-1] : 32'hA5A5_5A5A;
      if (k == 0) begin
        @(posedge hclk);
        #1;
        cyc++;
      end else begin
        e     = sb.pop_front();
        waits = 0;
        done  = 1'b0;
        for (int t = 0; t < 20 && !done; t++) begin
          @(negedge hclk);
          if (hready) begin
            chk("resp", {31'b0, hresp}, {31'b0, e.err});
            chk("rdata", rdata, (e.rd && !e.err) ? e.data : 32'h0);
            done = 1'b1;
          end else begin
            waits++;
            chk("wait_resp", {31'b0, hresp}, {31'b0, e.err});
            chk("wait_rdata", rdata, 32'h0);
          end
          @(posedge hclk);
          #1;
          cyc++;
        end
        chk("completed", {31'b0, done}, 32'h1);
        chk("waits", waits, e.waits);
      end
    end
    chk("cycles", cyc, exp_cyc);
    ntr = 0;
  endtask

  initial begin
    hresetn   = 1'b0;
    hsel      = 1'b0;
    haddr     = 32'h0;
    htrans    = 2'b00;
    hwrite    = 1'b0;
    hsize     = 3'b000;
    hwdata    = 32'h0;
    is_signed = 1'b0;
    use2      = 1'b0;
    #12;
    chk("rst_hready0", {31'b0, hrdy0}, 32'h1);
    chk("rst_hresp0", {31'b0, hresp0}, 32'h0);
    chk("rst_rdata0", rd0, 32'h0);
    chk("rst_hready2", {31'b0, hrdy2}, 32'h1);
    chk("rst_hresp2", {31'b0, hresp2}, 32'h0);
    chk("rst_rdata2", rd2, 32'h0);
    @(negedge hclk);
    hresetn = 1'b1;

    // Word write then read, zero wait states.
    add(1'b1, 32'h10, 3'd2, 1'b0, 32'hDEAD_BEEF);
    add(1'b0, 32'h10, 3'd2, 1'b0, 32'h0);
    run_burst();

    // Byte/half lanes and extension.
    add(1'b1, 32'h10, 3'd2, 1'b0, 32'h0);
    add(1'b1, 32'h13, 3'd0, 1'b0, 32'h8000_0000);
    add(1'b0, 32'h13, 3'd0, 1'b1, 32'h0);
    add(1'b0, 32'h13, 3'd0, 1'b0, 32'h0);
    add(1'b0, 32'h10, 3'd2, 1'b0, 32'h0);
    add(1'b1, 32'h12, 3'd1, 1'b0, 32'h8001_5555);
    add(1'b0, 32'h12, 3'd1, 1'b1, 32'h0);
    add(1'b0, 32'h10, 3'd1, 1'b0, 32'h0);
    add(1'b0, 32'h11, 3'd0, 1'b1, 32'h0);
    run_burst();

    // Error responses and the top-of-range boundary.
    add(1'b1, 32'h0, 3'd2, 1'b0, 32'h1234_5678);
    add(1'b1, 32'h1, 3'd1, 1'b0, 32'hFFFF_FFFF);
    add(1'b0, 32'h0, 3'd2, 1'b0, 32'h0);
    add(1'b0, 32'h4, 3'd3, 1'b0, 32'h0);
    add(1'b1, 32'h12, 3'd2, 1'b0, 32'h1);
    add(1'b1, 32'h1000, 3'd2, 1'b0, 32'h1);
    add(1'b1, 32'hFFC, 3'd2, 1'b0, 32'hCAFE_F00D);
    add(1'b0, 32'hFFC, 3'd2, 1'b0, 32'h0);
    add(1'b0, 32'h0, 3'd2, 1'b0, 32'h0);
    run_burst();

    // Four pipelined writes then reads, one transfer per cycle.
    for (int i = 0; i < 4; i++) add(1'b1, 32'h40 + 32'(4 * i), 3'd2, 1'b0, 32'h0101_0101 * 32'(i + 3));
    for (int i = 0; i < 4; i++) add(1'b0, 32'h40 + 32'(4 * i), 3'd2, 1'b0, 32'h0);
    run_burst();

    // Two wait states.
    use2 = 1'b1;
    add(1'b1, 32'h20, 3'd2, 1'b0, 32'h1111_1111);
    add(1'b0, 32'h20, 3'd2, 1'b0, 32'h0);
    add(1'b1, 32'h7, 3'd1, 1'b0, 32'h0);
    add(1'b0, 32'h23, 3'd0, 1'b1, 32'h0);
    run_burst();

    // Reset during the wait phase of a write aborts it.
    hsel   = 1'b1;
    htrans = 2'b10;
    haddr  = 32'h20;
    hwrite = 1'b1;
    hsize  = 3'd2;
    @(posedge hclk);
    #1;
    hsel   = 1'b0;
    htrans = 2'b00;
    hwdata = 32'h2222_2222;
    @(negedge hclk);
    chk("t6_in_wait", {31'b0, hready}, 32'h0);
    hresetn = 1'b0;
    #1;
    chk("t6_rst_hready", {31'b0, hready}, 32'h1);
    chk("t6_rst_hresp", {31'b0, hresp}, 32'h0);
    chk("t6_rst_rdata", rdata, 32'h0);
    @(posedge hclk);
    #1;
    chk("t6_hold_hready", {31'b0, hready}, 32'h1);
    @(negedge hclk);
    hresetn = 1'b1;
    hwdata  = 32'hA5A5_5A5A;
    add(1'b0, 32'h20, 3'd2, 1'b0, 32'h0);
    run_burst();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
